fcvt_issue_ctrl: RTL

// - Sequences FCVT.WU.S (and optionally FCVT.W.S) ops from the FPU issue stage through the shared combinational float->uint datapath.
// - Accepts one request at a time and resolves dynamic rounding mode (rm=111 -> frm CSR).
// - Holds datapath inputs stable for LATENCY cycles, applies sign/overflow fixups, generates fflags and returns a tagged response.

---
 rtl/fcvt_issue_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/fcvt_issue_ctrl.sv
// fcvt_issue_ctrl: single-issue sequencer for FCVT.WU.S around a shared multicycle float->uint
// datapath. Define FCVT_SIGNED_EN to also sequence FCVT.W.S (sign strip, rm remap, saturation).
module fcvt_issue_ctrl #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_src,
  input  logic [2:0]       req_rm,
  input  logic             req_signed,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [2:0]       frm,
  input  logic             flush,
  output logic [31:0]      dp_float_in,
  output logic [2:0]       dp_rm,
  input  logic [31:0]      dp_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic [4:0]       resp_fflags,
  output logic             resp_illegal
);
  localparam int unsigned     CntW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [31:0]      src_q;
  logic [TAG_W-1:0] tag_q;
  logic [2:0]       rm_q;

  logic [2:0]  acc_rm_eff;
  logic [2:0]  acc_dp_rm;
  logic [31:0] acc_dp_float;
  logic        accept;

  assign req_ready  = (state_q == StIdle);
  assign accept     = req_ready && req_valid && !flush;
  assign acc_rm_eff = (req_rm == 3'b111) ? frm : req_rm;

`ifdef FCVT_SIGNED_EN
  logic signed_q;

  // Datapath only sees magnitudes; directed modes flip meaning for negative operands.
  always_comb begin
    acc_dp_float = req_signed ? {1'b0, req_src[30:0]} : req_src;
    acc_dp_rm    = acc_rm_eff;
    if (req_signed && req_src[31]) begin
      if (acc_rm_eff == 3'b010) begin
        acc_dp_rm = 3'b011;
      end else if (acc_rm_eff == 3'b011) begin
        acc_dp_rm = 3'b001;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      signed_q <= 1'b0;
    end else if (accept) begin
      signed_q <= req_signed;
    end
  end
`else
  logic unused_signed;
  assign unused_signed = req_signed;
  assign acc_dp_float  = req_src;
  assign acc_dp_rm     = acc_rm_eff;
`endif

  // Operand decode of the captured source.
  logic        sign;
  logic [7:0]  exp;
  logic [22:0] man;
  logic        is_nan;
  logic        huge;
  logic        illegal;
  logic        inexact;
  logic        neg_mag_nz;
  logic [23:0] frac_mask;

  assign sign    = src_q[31];
  assign exp     = src_q[30:23];
  assign man     = src_q[22:0];
  assign is_nan  = (exp == 8'hFF) && (man != '0);
  assign huge    = (exp >= 8'd159);
  assign illegal = (rm_q >= 3'b101);

  always_comb begin
    frac_mask = '0;
    if (exp >= 8'd127 && exp < 8'd150) begin
      frac_mask = (24'h1 << (8'd150 - exp)) - 24'h1;
    end
    if (exp < 8'd127) begin
      inexact = (exp != '0) || (man != '0);
    end else begin
      inexact = (man & frac_mask[22:0]) != '0;
    end
  end

  // Whether a negative operand rounds to a nonzero integer under rm_q.
  always_comb begin
    if (exp >= 8'd127) begin
      neg_mag_nz = 1'b1;
    end else if (exp == '0 && man == '0) begin
      neg_mag_nz = 1'b0;
    end else begin
      case (rm_q)
        3'b000:  neg_mag_nz = (exp == 8'd126) && (man != '0);
        3'b100:  neg_mag_nz = (exp == 8'd126);
        3'b010:  neg_mag_nz = 1'b1;
        default: neg_mag_nz = 1'b0;
      endcase
    end
  end

  logic [31:0] fix_data;
  logic        fix_nv;
  logic        fix_nx;

  always_comb begin
    fix_data = dp_result;
    fix_nv   = 1'b0;
    if (illegal) begin
      fix_data = '0;
    end
`ifdef FCVT_SIGNED_EN
    else if (signed_q) begin
      if (is_nan || (!sign && (huge || dp_result > 32'h7FFF_FFFF))) begin
        fix_data = 32'h7FFF_FFFF;
        fix_nv   = 1'b1;
      end else if (sign && (huge || dp_result > 32'h8000_0000)) begin
        fix_data = 32'h8000_0000;
        fix_nv   = 1'b1;
      end else if (sign) begin
        fix_data = 32'd0 - dp_result;
      end
    end
`endif
    else if (is_nan || (!sign && huge)) begin
      fix_data = 32'hFFFF_FFFF;
      fix_nv   = 1'b1;
    end else if (sign) begin
      fix_data = '0;
      fix_nv   = neg_mag_nz;
    end
    fix_nx = !illegal && !fix_nv && inexact;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      src_q        <= '0;
      tag_q        <= '0;
      rm_q         <= '0;
      dp_float_in  <= '0;
      dp_rm        <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_tag     <= '0;
      resp_fflags  <= '0;
      resp_illegal <= 1'b0;
    end else if (flush) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_tag     <= '0;
      resp_fflags  <= '0;
      resp_illegal <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            state_q     <= StExec;
            cnt_q       <= '0;
            src_q       <= req_src;
            tag_q       <= req_tag;
            rm_q        <= acc_rm_eff;
            dp_float_in <= acc_dp_float;
            dp_rm       <= acc_dp_rm;
          end
        end
        StExec: begin
          if (cnt_q == CntLast) begin
            state_q      <= StDone;
            resp_valid   <= 1'b1;
            resp_data    <= fix_data;
            resp_tag     <= tag_q;
            resp_fflags  <= {fix_nv, 3'b000, fix_nx};
            resp_illegal <= illegal;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (resp_ready) begin
            state_q      <= StIdle;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_tag     <= '0;
            resp_fflags  <= '0;
            resp_illegal <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
